button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Upstream stage of the up/down counter display path.
- Converts two raw, bouncing pushbuttons into clean control levels: enable (run/stop) and upDown (direction).
- Each button is 2-flop synchronized, debounced by a stability counter and edge-detected; each press toggles its output level.
- Runs on the undivided board clock; enable/upDown drive the counter stage directly.

Parameters:
- DB_CNT, 16, consecutive stable clk cycles needed to accept a new button level (boards override, e.g. 250000 for 5 ms at 50 MHz); legal range 2..2^24.
- CNT_W, 24, debounce counter width; must satisfy 2^CNT_W > DB_CNT.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- btnEnRaw  input  1  raw run/stop button, asynchronous, active-high
- btnDirRaw  input  1  raw direction button, asynchronous, active-high
- enable  output  1  run level to counter; toggles per accepted press
- upDown  output  1  direction level to counter; 1 = up, toggles per accepted press
- enPress  output  1  one-cycle pulse on accepted run/stop press
- dirPress  output  1  one-cycle pulse on accepted direction press

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - Sync flops, debounce counters and stable levels = 0; both FSMs to LO.
  - enable=0, upDown=1, enPress=0, dirPress=0.
- Synchronizer: raw -> s1 -> s2, both registered. s2 reflects a raw change after 2 edges.
- Debounce FSM, one independent copy per button, states LO, WAIT_HI, HI, WAIT_LO:
  - LO: s2=1 -> WAIT_HI, counter=1. Otherwise stay, counter=0.
  - WAIT_HI: s2=0 -> LO, counter=0 (glitch rejected).
  - WAIT_HI: s2=1 and counter=DB_CNT-1 -> HI, counter=0, press pulse=1.
  - WAIT_HI: otherwise counter+1.
  - HI: s2=0 -> WAIT_LO, counter=1. Otherwise stay.
  - WAIT_LO: s2=1 -> HI, counter=0.
  - WAIT_LO: s2=0 and counter=DB_CNT-1 -> LO, counter=0. Releases generate no pulse.
- Latency: raw rising edge held clean -> press pulse and output toggle at clk edge 2+DB_CNT after the first sampling edge.
- Pulses are registered, high exactly one cycle, never back-to-back. Minimum pulse spacing is 2*DB_CNT cycles (press + release).
- enable toggles on the edge enPress asserts. upDown toggles on the edge dirPress asserts. Output changes are glitch-free registered levels.
- Bounce shorter than DB_CNT cycles in any WAIT state returns to the prior stable state with no output change.
- Channels are fully independent. Simultaneous accepted presses toggle both outputs in the same cycle.
- Reset mid-debounce discards progress. A button held through reset release is seen as a new press: toggle after 2+DB_CNT cycles.
- Counter never exceeds DB_CNT-1; no wrap.

Optional Feature:
- Macro: BTN_HOLD_MODE_EN.
- Defined: enable equals the run/stop channel's debounced level (1 in HI/WAIT_LO, 0 in LO/WAIT_HI), i.e. count while held. Reset value 0. enPress is still generated; upDown is unchanged (toggle).
- Undefined: enable is toggle-per-press as above.

Test Plan:
- Reset: rst=1 for 2 cycles, buttons 0 -> enable=0, upDown=1, pulses 0. Hold 100 cycles, no change.
- Clean press, DB_CNT=16: btnEnRaw 0->1 held 40 cycles -> enPress high exactly 1 cycle at edge 18 after the first sampling edge; enable 0->1 on that edge. Release 40 cycles, press again -> enable 1->0.
- Bounce reject: btnDirRaw toggles with high/low runs of 5 cycles for 60 cycles, then 0 -> no dirPress, upDown stays 1.
- Bounce then settle: 5-cycle bounce runs for 30 cycles, then held 1 -> exactly one dirPress, 18 edges after the final rising transition is sampled; upDown 1->0.
- Simultaneous: both raw rise on the same edge -> enPress and dirPress in the same cycle; enable=1, upDown=0.
- Reset mid-debounce: press, assert rst at counter=10, keep button held, release rst -> outputs return to reset values, then toggle 18 edges after rst deasserts. With BTN_HOLD_MODE_EN: enable=1 while held, 0 after release is debounced.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: turns the raw run/stop and direction pushbuttons into
// clean control levels for the up/down counter stage.
// Each button has a 2-flop synchronizer, a stability-counter debounce FSM and
// a registered press pulse. By default each accepted press toggles its output.
// Build option BTN_HOLD_MODE_EN: enable follows the debounced run/stop level
// (count while held) instead of toggling; upDown always toggles.

// Debounce FSM states
//   state      | meaning
//   ST_LO      | button stably released
//   ST_WAIT_HI | s2 went high, counting stable-high cycles
//   ST_HI      | button stably pressed
//   ST_WAIT_LO | s2 went low, counting stable-low cycles
module btn_debounce #(
   parameter int DB_CNT   = 16,
   parameter int CNT_W    = 24,
   parameter bit HOLD     = 1'b0,
   parameter bit TOG_INIT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
);

   typedef enum logic [1:0] {
      ST_LO      = 2'd0,
      ST_WAIT_HI = 2'd1,
      ST_HI      = 2'd2,
      ST_WAIT_LO = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DB_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state, state_nxt;
   logic             s1, s2;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             press_nxt;
   logic             stable_q, stable_nxt;
   logic             toggle_q;

   // Synchronizer, FSM state, counter and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1       <= 1'b0;
         s2       <= 1'b0;
         state    <= ST_LO;
         cnt      <= '0;
         press    <= 1'b0;
         stable_q <= 1'b0;
         toggle_q <= TOG_INIT;
      end else begin
         s1       <= raw;
         s2       <= s1;
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         press    <= press_nxt;
         stable_q <= stable_nxt;
         toggle_q <= toggle_q ^ press_nxt;
      end
   end

   // Next state, stability counter and press detect; only press edges pulse.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      press_nxt = 1'b0;
      case (state)
         ST_LO: begin
            if (s2) begin
               state_nxt = ST_WAIT_HI;
               cnt_nxt   = CNT_ONE;
            end else begin
               cnt_nxt   = '0;
            end
         end
         ST_WAIT_HI: begin
            if (!s2) begin
               state_nxt = ST_LO;
               cnt_nxt   = '0;
            end else if (cnt == CNT_TC) begin
               state_nxt = ST_HI;
               cnt_nxt   = '0;
               press_nxt = 1'b1;
            end else begin
               cnt_nxt   = cnt + CNT_ONE;
            end
         end
         ST_HI: begin
            if (!s2) begin
               state_nxt = ST_WAIT_LO;
               cnt_nxt   = CNT_ONE;
            end else begin
               cnt_nxt   = '0;
            end
         end
         ST_WAIT_LO: begin
            if (s2) begin
               state_nxt = ST_HI;
               cnt_nxt   = '0;
            end else if (cnt == CNT_TC) begin
               state_nxt = ST_LO;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = ST_LO;
            cnt_nxt   = '0;
         end
      endcase
      stable_nxt = (state_nxt == ST_HI) || (state_nxt == ST_WAIT_LO);
   end

   // Both candidates are flops, so the selected level is glitch-free.
   assign level = HOLD ? stable_q : toggle_q;

endmodule

module button_conditioner #(
   parameter int DB_CNT = 16,
   parameter int CNT_W  = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic btnEnRaw,
   input  logic btnDirRaw,
   output logic enable,
   output logic upDown,
   output logic enPress,
   output logic dirPress
);

`ifdef BTN_HOLD_MODE_EN
   localparam bit EN_HOLD = 1'b1;
`else
   localparam bit EN_HOLD = 1'b0;
`endif

   btn_debounce #(
      .DB_CNT   (DB_CNT),
      .CNT_W    (CNT_W),
      .HOLD     (EN_HOLD),
      .TOG_INIT (1'b0)
   ) u_en (
      .clk   (clk),
      .rst   (rst),
      .raw   (btnEnRaw),
      .level (enable),
      .press (enPress)
   );

   // Direction resets to "up".
   btn_debounce #(
      .DB_CNT   (DB_CNT),
      .CNT_W    (CNT_W),
      .HOLD     (1'b0),
      .TOG_INIT (1'b1)
   ) u_dir (
      .clk   (clk),
      .rst   (rst),
      .raw   (btnDirRaw),
      .level (upDown),
      .press (dirPress)
   );

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at DB_CNT=16.
// Expected enable is selected per build (toggle vs BTN_HOLD_MODE_EN hold mode).
module tb_button_conditioner;

`ifdef BTN_HOLD_MODE_EN
   localparam bit EN_HOLD = 1'b1;
`else
   localparam bit EN_HOLD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic btnEnRaw;
   logic btnDirRaw;
   logic enable;
   logic upDown;
   logic enPress;
   logic dirPress;

   int checks = 0;
   int errors = 0;
   int en_cnt;
   int dir_cnt;

   typedef struct {
      bit rst;
      bit en_raw;
      bit dir_raw;
      int cycles;
      bit en_tog;
      bit en_hold;
      bit ud;
      int en_p;
      int dir_p;
   } seg_t;

   seg_t tbl[8];

   button_conditioner #(.DB_CNT(16), .CNT_W(24)) dut (
      .clk       (clk),
      .rst       (rst),
      .btnEnRaw  (btnEnRaw),
      .btnDirRaw (btnDirRaw),
      .enable    (enable),
      .upDown    (upDown),
      .enPress   (enPress),
      .dirPress  (dirPress)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      en_cnt  += int'(enPress);
      dir_cnt += int'(dirPress);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic int exp_en(input bit tog, input bit hold);
      return EN_HOLD ? int'(hold) : int'(tog);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_en, first_dir, en_at17, en_at18;

      rst = 1'b1; btnEnRaw = 1'b0; btnDirRaw = 1'b0;

      //          rst en dir cyc tog hold ud enp dirp
      tbl[0] = '{1'b1, 1'b0, 1'b0,   2, 1'b0, 1'b0, 1'b1, 0, 0};
      tbl[1] = '{1'b0, 1'b0, 1'b0, 100, 1'b0, 1'b0, 1'b1, 0, 0};
      tbl[2] = '{1'b0, 1'b1, 1'b0,  40, 1'b1, 1'b1, 1'b1, 1, 0};
      tbl[3] = '{1'b0, 1'b0, 1'b0,  40, 1'b1, 1'b0, 1'b1, 0, 0};
      tbl[4] = '{1'b0, 1'b1, 1'b0,  40, 1'b0, 1'b1, 1'b1, 1, 0};
      tbl[5] = '{1'b0, 1'b0, 1'b0,  40, 1'b0, 1'b0, 1'b1, 0, 0};
      tbl[6] = '{1'b0, 1'b1, 1'b1,  40, 1'b1, 1'b1, 1'b0, 1, 1};
      tbl[7] = '{1'b0, 1'b0, 1'b0,  40, 1'b1, 1'b0, 1'b0, 0, 0};

      for (int r = 0; r < 8; r++) begin
         rst = tbl[r].rst; btnEnRaw = tbl[r].en_raw; btnDirRaw = tbl[r].dir_raw;
         en_cnt = 0; dir_cnt = 0;
         ticks(tbl[r].cycles);
         chk($sformatf("row%0d enable", r), int'(enable), exp_en(tbl[r].en_tog, tbl[r].en_hold));
         chk($sformatf("row%0d upDown", r), int'(upDown), int'(tbl[r].ud));
         chk($sformatf("row%0d enPress count", r), en_cnt, tbl[r].en_p);
         chk($sformatf("row%0d dirPress count", r), dir_cnt, tbl[r].dir_p);
      end

      // Exact press latency and toggle timing on the run/stop channel.
      btnEnRaw = 1'b1;
      en_cnt = 0; first_en = 0; en_at17 = -1; en_at18 = -1;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (enPress && first_en == 0) first_en = i;
         if (i == 17) en_at17 = int'(enable);
         if (i == 18) en_at18 = int'(enable);
      end
      chk("latency enPress edge", first_en, 18);
      chk("latency enPress count", en_cnt, 1);
      chk("latency enable before", en_at17, exp_en(1'b1, 1'b0));
      chk("latency enable at pulse", en_at18, exp_en(1'b0, 1'b1));
      btnEnRaw = 1'b0;
      ticks(40);
      chk("latency release enable", int'(enable), exp_en(1'b0, 1'b0));

      // Reset again, then direction bounce with 5-cycle runs must be rejected.
      rst = 1'b1;
      ticks(2);
      chk("reset2 enable", int'(enable), 0);
      chk("reset2 upDown", int'(upDown), 1);
      rst = 1'b0;
      dir_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         btnDirRaw = 1'b1; ticks(5);
         btnDirRaw = 1'b0; ticks(5);
      end
      ticks(40);
      chk("bounce dirPress count", dir_cnt, 0);
      chk("bounce upDown", int'(upDown), 1);

      // Bounce then settle high: one press 18 edges after the final rise.
      for (int k = 0; k < 3; k++) begin
         btnDirRaw = 1'b1; ticks(5);
         btnDirRaw = 1'b0; ticks(5);
      end
      btnDirRaw = 1'b1;
      dir_cnt = 0; first_dir = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (dirPress && first_dir == 0) first_dir = i;
      end
      chk("settle dirPress edge", first_dir, 18);
      chk("settle dirPress count", dir_cnt, 1);
      chk("settle upDown", int'(upDown), 0);
      btnDirRaw = 1'b0;
      ticks(40);

      // Simultaneous presses pulse in the same cycle.
      btnEnRaw = 1'b1; btnDirRaw = 1'b1;
      en_cnt = 0; dir_cnt = 0; first_en = 0; first_dir = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (enPress && first_en == 0) first_en = i;
         if (dirPress && first_dir == 0) first_dir = i;
      end
      chk("simul enPress edge", first_en, 18);
      chk("simul dirPress edge", first_dir, 18);
      chk("simul enable", int'(enable), exp_en(1'b1, 1'b1));
      chk("simul upDown", int'(upDown), 1);
      btnEnRaw = 1'b0; btnDirRaw = 1'b0;
      ticks(40);

      // Reset mid-debounce with the button held through reset release.
      btnEnRaw = 1'b1;
      en_cnt = 0;
      ticks(12);
      chk("middeb no early press", en_cnt, 0);
      rst = 1'b1;
      ticks(2);
      chk("middeb reset enable", int'(enable), 0);
      chk("middeb reset upDown", int'(upDown), 1);
      chk("middeb reset enPress", int'(enPress), 0);
      rst = 1'b0;
      en_cnt = 0; first_en = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (enPress && first_en == 0) first_en = i;
      end
      chk("middeb enPress edge", first_en, 18);
      chk("middeb enPress count", en_cnt, 1);
      chk("middeb enable held", int'(enable), exp_en(1'b1, 1'b1));
      btnEnRaw = 1'b0;
      ticks(40);
      chk("middeb enable released", int'(enable), exp_en(1'b1, 1'b0));
      chk("middeb upDown final", int'(upDown), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
